// File: rtl/fft_reorder_unload.sv
// fft_reorder_unload: captures bit-reversed 16-bin frames into ping-pong banks and streams them out in natural order
module fft_reorder_unload #(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in0_R,
    input  logic [DW-1:0] in0_I,
    input  logic [DW-1:0] in1_R,
    input  logic [DW-1:0] in1_I,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out0_R,
    output logic [DW-1:0] out0_I,
    output logic [DW-1:0] out1_R,
    output logic [DW-1:0] out1_I,
    output logic [2:0]    out_beat,
    output logic          out_last,
    output logic          ovf,
    output logic          sync_err,
    output logic [7:0]    frame_cnt
);
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    wstate_t ws_q;
    rstate_t rs_q;
    logic [2*DW-1:0] mem_q [2][16];
    logic [1:0] full_q;
    logic [2:0] k_q, out_beat_q;
    logic wb_q, rb_q, ovf_q, sync_err_q, out_valid_q, out_last_q;
    logic [4*DW-1:0] out_data_q;
    logic [7:0] frame_cnt_q;
    logic wr_start, wr_go, we, set_full, acc, ld0, ldn, ld, clr_full;
    logic [2:0] wk, nxt, ld_beat_d;

    assign wr_start  = in_valid & in_sof & (ws_q == W_FILL | !full_q[wb_q]);
    assign wr_go     = in_valid & !in_sof & ws_q == W_FILL;
    assign we        = wr_start | wr_go;
    assign wk        = wr_start ? 3'd0 : k_q;
    assign set_full  = wr_go & k_q == 3'd7;
    assign acc       = out_valid_q & out_ready;
    assign ld0       = full_q[rb_q] & (rs_q == R_IDLE | acc & out_last_q);
    assign ldn       = acc & !out_last_q;
    assign ld        = ld0 | ldn;
    assign nxt       = out_beat_q + 3'd1;
    assign ld_beat_d = ld0 ? 3'd0 : nxt;
    assign clr_full  = ldn & nxt == 3'd7;

    assign out_valid = out_valid_q;
    assign {out0_R, out0_I, out1_R, out1_I} = out_data_q;
    assign out_beat  = out_beat_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;
    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;

    // Stream index {k,j} lands at bin {j,k[0],k[1],k[2]} so the bank holds natural order
    always_ff @(posedge clk)
        if (we) begin
            mem_q[wb_q][{1'b0, wk[0], wk[1], wk[2]}] <= {in0_R, in0_I};
            mem_q[wb_q][{1'b1, wk[0], wk[1], wk[2]}] <= {in1_R, in1_I};
        end

    // Writer: frame alignment, beat counting, overflow drop and bank hand-off
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ws_q       <= W_IDLE;
            k_q        <= 3'd0;
            wb_q       <= 1'b0;
            ovf_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else if (in_valid) begin
            if (in_sof) begin
                sync_err_q <= sync_err_q | ws_q == W_FILL;
                ovf_q      <= ovf_q | !wr_start;
                ws_q       <= wr_start ? W_FILL : W_DROP;
                k_q        <= wr_start ? 3'd1 : 3'd0;
            end else if (ws_q == W_FILL) begin
                ws_q <= k_q == 3'd7 ? W_IDLE : W_FILL;
                wb_q <= wb_q ^ (k_q == 3'd7);
                k_q  <= k_q + 3'd1;
            end else begin
                sync_err_q <= sync_err_q | ws_q == W_IDLE;
            end
        end

    // Bank occupancy: writer and reader only ever touch different banks in one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            full_q <= 2'b00;
        end else begin
            if (set_full) full_q[wb_q] <= 1'b1;
            if (clr_full) full_q[rb_q] <= 1'b0;
        end

    // Reader: registered output beats, released to the next bank as soon as beat 7 is loaded
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rs_q        <= R_IDLE;
            rb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beat_q  <= 3'd0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            if (acc & out_last_q) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (ld) begin
                rs_q        <= R_SEND;
                out_valid_q <= 1'b1;
                out_beat_q  <= ld_beat_d;
                out_last_q  <= ld_beat_d == 3'd7;
                rb_q        <= rb_q ^ (ld_beat_d == 3'd7);
                out_data_q  <= {mem_q[rb_q][{ld_beat_d, 1'b0}], mem_q[rb_q][{ld_beat_d, 1'b1}]};
            end else if (acc) begin
                rs_q        <= R_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_fft_reorder_unload.sv
// tb_fft_reorder_unload: directed frames checked against a frame-level reorder model and scoreboard
module tb_fft_reorder_unload;
    localparam int DW = 17;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in0_R = '0, in0_I = '0, in1_R = '0, in1_I = '0;
    logic out_valid, out_last, ovf, sync_err;
    logic [DW-1:0] out0_R, out0_I, out1_R, out1_I;
    logic [2:0] out_beat;
    logic [7:0] frame_cnt;

    typedef struct packed {
        logic [DW-1:0] r0, i0, r1, i1;
        logic [2:0] beat;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur, prev;
    bit prev_stall = 0;
    logic [DW-1:0] fr[16], fi[16];
    int tests = 0, fails = 0, run = 0, last_run = 0;

    fft_reorder_unload #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in0_R(in0_R), .in0_I(in0_I), .in1_R(in1_R), .in1_I(in1_I),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0_R(out0_R), .out0_I(out0_I), .out1_R(out1_R), .out1_I(out1_I),
        .out_beat(out_beat), .out_last(out_last), .ovf(ovf), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int rev4(input int v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r |= 1 << (3 - i);
        return r;
    endfunction

    task automatic gen(input int rb, input int ib, input int is);
        for (int n = 0; n < 16; n++) begin
            fr[n] = DW'(rb + n);
            fi[n] = DW'(ib + is * n);
        end
    endtask

    // Bin b of a frame holds stream sample rev4(b); beat m carries bins 2m and 2m+1
    task automatic push_exp();
        beat_t b;
        for (int m = 0; m < 8; m++) begin
            b.r0 = fr[rev4(2 * m)];
            b.i0 = fi[rev4(2 * m)];
            b.r1 = fr[rev4(2 * m + 1)];
            b.i1 = fi[rev4(2 * m + 1)];
            b.beat = 3'(m);
            b.last = (m == 7);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive(input int k, input bit sof);
        in_valid = 1'b1;
        in_sof = sof;
        in0_R = fr[2 * k];
        in0_I = fi[2 * k];
        in1_R = fr[2 * k + 1];
        in1_I = fi[2 * k + 1];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame();
        for (int k = 0; k < 8; k++) drive(k, k == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted beat must match the model; stalled beats must hold
    always @(negedge clk) begin
        cur = {out0_R, out0_I, out1_R, out1_I, out_beat, out_last};
        if (rst) begin
            prev_stall = 0;
            run = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", cur, prev);
            end
            if (out_valid) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
                else chk("out_beat_data", cur, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_beat", out_beat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sync", sync_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_data", {out0_R, out1_I}, 0);
        rst = 1'b0;
        idle(2);

        out_ready = 1'b1;
        gen(0, 0, 0);
        push_exp();
        chk("model_b1_r0", exp_q[1].r0, 4);
        chk("model_b1_r1", exp_q[1].r1, 12);
        chk("model_b7_r0", exp_q[7].r0, 7);
        chk("model_b7_r1", exp_q[7].r1, 15);
        send_frame();
        chk("lat_edge_t", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge_t1", out_valid, 1);
        chk("lat_b0", {out0_R, out1_R, out_beat}, {17'd0, 17'd8, 3'd0});
        wait_drain("single");
        chk("single_cnt", frame_cnt, 1);

        gen(100, 50, 1);
        push_exp();
        send_frame();
        gen(200, -7, -5);
        push_exp();
        send_frame();
        wait_drain("b2b");
        idle(2);
        chk("b2b_no_gap", last_run, 16);
        chk("b2b_cnt", frame_cnt, 3);
        chk("b2b_ovf", ovf, 0);

        out_ready = 1'b0;
        gen(300, 1, 2);
        push_exp();
        send_frame();
        gen(400, 3, 4);
        push_exp();
        send_frame();
        gen(500, 5, 6);
        send_frame();
        chk("drop_ovf", ovf, 1);
        chk("drop_stalled", {out_valid, out_beat}, {1'b1, 3'd0});
        idle(2);
        out_ready = 1'b1;
        wait_drain("drop");
        idle(2);
        chk("drop_cnt", frame_cnt, 5);
        chk("drop_sync", sync_err, 0);

        out_ready = 1'b0;
        fork
            begin
                gen(600, 9, 3);
                push_exp();
                send_frame();
                gen(700, -20, 7);
                push_exp();
                send_frame();
            end
            repeat (60) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        join
        out_ready = 1'b1;
        wait_drain("stall");
        chk("stall_cnt", frame_cnt, 7);

        gen(800, 0, 1);
        for (int k = 0; k < 4; k++) drive(k, k == 0);
        gen(900, 11, -1);
        push_exp();
        send_frame();
        wait_drain("resync");
        chk("resync_err", sync_err, 1);
        chk("resync_cnt", frame_cnt, 8);

        out_ready = 1'b0;
        gen(1000, 2, 2);
        push_exp();
        send_frame();
        c = 0;
        while (!out_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("rst_mid_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rst_mid_beat3", out_beat, 3);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_async_valid", out_valid, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_after", {ovf, sync_err, frame_cnt, out_beat}, 0);

        out_ready = 1'b1;
        gen(1100, 0, 1);
        drive(0, 0);
        chk("stray_sync", sync_err, 1);
        idle(20);
        chk("stray_no_out", {out_valid, frame_cnt}, 0);

        gen(1200, 4, -2);
        push_exp();
        send_frame();
        wait_drain("post_rst");
        chk("post_rst_cnt", frame_cnt, 1);

        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_reorder_unload.md
# fft_reorder_unload

Output-side companion to the 16-point `fft` core. Captures the core's two-sample-per-cycle complex result stream, which arrives in bit-reversed bin order. Reorders each 16-bin frame into natural order in a ping-pong register buffer. Presents it two bins per cycle over a valid/ready handshake to the downstream consumer (magnitude, writeback or checker logic).

## Interface
- `DW`, default 17: width of each real/imag component (two's complement, same format as the `fft` data ports).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: input beat present.
- `in_sof` in 1: qualifies beat 0 of a frame.
- `in0_R`, `in0_I`, `in1_R`, `in1_I` in DW each: stream samples 2k and 2k+1 of beat k. These are the `fft` data_o0/data_o1 outputs.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: consumer accepts the output beat.
- `out0_R`, `out0_I`, `out1_R`, `out1_I` out DW each: bins 2m and 2m+1.
- `out_beat` out 3: m, 0..7.
- `out_last` out 1: high when m = 7.
- `ovf` out 1: sticky; a frame was dropped because both banks were full.
- `sync_err` out 1: sticky; a frame-alignment error occurred.
- `frame_cnt` out 8: number of frames fully delivered; wraps 255 -> 0.

## Operation
- Two banks, A and B. Each bank holds 16 entries of 2*DW bits in flops. Each bank has a `full` flag.
- Write mapping: stream index n = 2k + j (j = 0 for in0, 1 for in1) is stored at bin address bitrev4(n).
  - Beat 0 gives bins 0 and 8.
  - Beat 1 gives bins 4 and 12.
  - Beat 7 gives bins 7 and 15.
- Writer FSM:
  - W_IDLE: a beat with `in_valid & in_sof` starts a frame into the write bank. If the write bank is not full, write the beat, set k = 1 and go to W_FILL. If it is full, set `ovf` and go to W_DROP. A beat with `in_valid & !in_sof` is discarded and sets `sync_err`.
  - W_FILL: each `in_valid` beat writes beat k and increments k. When beat 7 is written, set the bank's `full` flag, toggle the write bank and go to W_IDLE. A beat with `in_sof` while k != 0 discards the partial frame (bank not marked full), sets `sync_err`, and restarts the frame with this beat as beat 0 (k = 1). Gaps in `in_valid` are allowed.
  - W_DROP: discard beats until the beat with `in_sof & in_valid`, which is handled as in W_IDLE.
- Reader FSM:
  - R_IDLE: when the read bank is `full`, load output beat 0 into the output registers and go to R_SEND.
  - R_SEND: on `out_valid & out_ready`, load the next beat m+1.
  - When beat 7 is loaded, clear the read bank's `full` flag and toggle the read bank. The bank is free at that edge.
  - On acceptance of the `out_last` beat, increment `frame_cnt`. Then load beat 0 of the other bank if it is `full` (no bubble); otherwise go to R_IDLE with `out_valid` = 0.
- Output beat m drives bins 2m and 2m+1 on `out0` and `out1`. Data passes through unmodified; no arithmetic is applied.
- Simultaneous events: a writer `full` set and a reader `full` clear on the same edge act on different banks and both take effect. Setting `full` in the same edge that the reader checks it is seen the following cycle.

## Timing
- Reset values:
  - `out_valid` = 0; `out*_R`/`out*_I` = 0; `out_beat` = 0; `out_last` = 0.
  - `ovf` = 0; `sync_err` = 0; `frame_cnt` = 0.
  - Both `full` flags = 0; write bank = A; read bank = A; both FSMs idle.
- Reset mid-operation discards all buffered data immediately (asynchronous).
- Latency: beat 7 is sampled at edge t, which sets `full`. Output beat 0 is valid after edge t+1.
- Throughput: 1 beat per cycle sustained. With `out_ready` held at 1 and frames arriving back-to-back (8 consecutive beats each), there are no drops and no output gaps.
- Handshake: `out_valid`, once high, stays high until accepted. Output data, `out_beat` and `out_last` are held stable while `out_valid & !out_ready`.
- Back-pressure only stalls the reader. The writer never stalls; the overflow rule applies.

## Test plan
- Single frame, in_R[n] = n, in_I = 0, beats 0..7, `out_ready` = 1 -> after the latency, beats carry (out0_R, out1_R) = (bitrev(0), bitrev(1)) = (0, 8), then (4, 12), …, then (7, 15) on beat 7. `out_last` is high only on beat 7. `frame_cnt` = 1.
- Stream index n is stored at bin bitrev(n) and bins are read out in order, so beat m carries (bitrev(2m), bitrev(2m+1)).
- Two back-to-back frames, `out_ready` = 1 -> 16 consecutive valid output beats with no gap, `frame_cnt` = 2, `ovf` = 0.
- Three back-to-back frames, `out_ready` held at 0 -> frames 1 and 2 are buffered and frame 3 is dropped, `ovf` = 1. After `out_ready` is raised, exactly 16 beats from frames 1 and 2 are delivered and `frame_cnt` = 2.
- Random `out_ready` stalls -> output data, `out_beat` and `out_last` are held while stalled; the output bin sequence matches the no-stall case.
- `in_sof` reasserted at beat 4 -> `sync_err` = 1, and only the restarted frame is delivered. A stray beat without `in_sof` while idle -> `sync_err` = 1 and no output is produced.
- `rst` pulsed while bank A is full and output beat 3 is pending -> `out_valid` drops to 0 at once. All flags and counters read 0 afterwards, and the next frame is delivered normally.
